mem_io_bridge: RTL and testbench
================================

MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16, CPU/SRAM data width.
REQ-002 SHALL have parameter ADDR_W, default 16, address width.
REQ-003 SHALL have parameter SW_W, default 10, switch and LED width (SW_W <= DATA_W).
REQ-004 SHALL have parameter NUM_HEX, default 4, hex nibbles driven (4*NUM_HEX <= DATA_W).
REQ-005 SHALL have parameter WAIT_CYC, default 1, range 0..15, extra SRAM strobe cycles.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: Clk in 1, rising-edge clock; Reset_n in 1, async active-low reset.
REQ-007 SHALL have these CPU-side ports: Req in 1, access request; Wr in 1, 1=write 0=read; Addr in ADDR_W; Wdata in DATA_W; Rdata out DATA_W, read result; Ready out 1, completion pulse; Busy out 1, access in progress.
REQ-008 SHALL have these I/O ports: Switches in SW_W; Hex out 4*NUM_HEX, hex nibbles, nibble 0 at LSBs; LED out SW_W.
REQ-009 SHALL have these SRAM-side ports: SRAM_ADDR out ADDR_W; SRAM_Dout out DATA_W; SRAM_Din in DATA_W; SRAM_OE_n out 1, active-low; SRAM_WE_n out 1, active-low.

Function
REQ-010 SHALL implement the states IDLE, ACCESS and DONE; Busy=1 in ACCESS and DONE.
REQ-011 SHALL sample Req only in IDLE; on a rising edge with Req=1 it SHALL latch Addr, Wr and Wdata; Req in ACCESS/DONE is ignored, not queued.
REQ-012 SHALL decode MMIO_SW_HEX = all-ones address: read returns Switches zero-extended; write loads Hex from latched Wdata[4*NUM_HEX-1:0].
REQ-013 SHALL handle an MMIO access as IDLE->DONE, with no SRAM strobe asserted.
REQ-014 SHALL handle a non-MMIO access as IDLE->ACCESS; ACCESS lasts exactly WAIT_CYC+1 cycles, counted by a 4-bit down-counter, then ->DONE.
REQ-015 SHALL, during ACCESS, drive SRAM_ADDR=latched address; read: SRAM_OE_n=0; write: SRAM_WE_n=0 and SRAM_Dout=latched Wdata.
REQ-016 SHALL keep SRAM_OE_n=SRAM_WE_n=1 outside ACCESS; both SHALL never be 0 simultaneously.
REQ-017 SHALL, for a read, capture SRAM_Din into Rdata on the final ACCESS edge.
REQ-018 SHALL assert Ready for exactly one cycle in DONE, then go DONE->IDLE unconditionally.
REQ-019 SHALL hold Rdata until the next read completes; writes SHALL not alter Rdata.
REQ-020 SHALL meet this latency from the accepting edge: MMIO Ready the next cycle; SRAM Ready WAIT_CYC+2 cycles later.
REQ-021 SHALL take Hex/LED writes effect on the IDLE->DONE edge.

Reset
REQ-022 SHALL, on Reset_n=0 (asynchronous, including mid-ACCESS), force: state IDLE, Ready=0, Busy=0, Rdata=0, Hex=0, LED=0, SRAM_OE_n=1, SRAM_WE_n=1, SRAM_ADDR=0, SRAM_Dout=0, counter=0.
REQ-023 SHALL deliver no Ready pulse for an access aborted by reset.

Configuration
REQ-024 SHALL, with macro MEM_IO_LED_EN defined, decode address all-ones minus 1 as an LED register: write loads LED from Wdata[SW_W-1:0]; read returns LED zero-extended; MMIO timing per REQ-013.
REQ-025 SHALL, without MEM_IO_LED_EN, route that address to SRAM like any other address and tie LED to 0.

Structure
REQ-026 SHALL place the state enum and MMIO address functions (parametrised on ADDR_W) in package mem_io_pkg.
REQ-027 SHALL implement the wait-state counter as sub-module mem_io_wait_ctr (load WAIT_CYC, decrement, done flag).

Verification
REQ-028 SHALL cover: SRAM read, WAIT_CYC=1, Addr=0x0010, SRAM_Din=0xBEEF -> OE_n low 2 cycles, Ready 3 cycles after accept, Rdata=0xBEEF.
REQ-029 SHALL cover: write Addr=0xFFFF, Wdata=0x1234 -> Hex=0x1234 next edge, Ready after 1 cycle, WE_n/OE_n stay 1.
REQ-030 SHALL cover: read Addr=0xFFFF, Switches=0x2A5 -> Rdata=0x02A5, Ready after 1 cycle.
REQ-031 SHALL cover: Req held high in ACCESS/DONE -> exactly one access per IDLE acceptance, no queued transaction.
REQ-032 SHALL cover: Reset_n low during an SRAM write ACCESS -> WE_n=1 immediately, no Ready, Hex=0, state IDLE.
REQ-033 SHALL cover, with MEM_IO_LED_EN: write Addr=0xFFFE, Wdata=0x03FF -> LED=0x3FF; without it, the same write strobes WE_n at 0xFFFE.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and MMIO address decode helpers for the memory/IO bridge.
package mem_io_pkg;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Widest address the decode helpers can describe.
  localparam int unsigned MAX_ADDR_W = 64;

  // All-ones address of width addr_w: switches read / hex write register.
  function automatic logic [MAX_ADDR_W-1:0] sw_hex_addr(input int unsigned addr_w);
    return {MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - addr_w);
  endfunction

  // One below the switch/hex register: optional LED register.
  function automatic logic [MAX_ADDR_W-1:0] led_addr(input int unsigned addr_w);
    return sw_hex_addr(addr_w) - MAX_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side request/response bus of the memory/IO bridge.
interface mem_io_bridge_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              Req;
  logic              Wr;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Wdata;
  logic [DATA_W-1:0] Rdata;
  logic              Ready;
  logic              Busy;

  modport master (output Req, Wr, Addr, Wdata, input Rdata, Ready, Busy);
  modport slave  (input Req, Wr, Addr, Wdata, output Rdata, Ready, Busy);
endinterface

// File: rtl/mem_io_wait_ctr.sv
// 4-bit wait-state down-counter: load WAIT_CYC, decrement, flag zero.
module mem_io_wait_ctr #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic done_c_o
);
  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt_q;

  // Load on access start, count down while the strobe is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CNT_W'(WAIT_CYC);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c_o = (cnt_q == '0);
endmodule

// File: rtl/mem_io_bridge.sv
// CPU to SRAM / memory-mapped IO bridge.
// Optional feature: define MEM_IO_LED_EN to add an LED register at the
// address just below the switch/hex register; otherwise that address goes
// to SRAM and LED is tied low.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned SW_W     = 10,
  parameter int unsigned NUM_HEX  = 4,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  mem_io_bridge_if.slave       cpu,
  input  logic [SW_W-1:0]      Switches,
  output logic [4*NUM_HEX-1:0] Hex,
  output logic [SW_W-1:0]      LED,
  output logic [ADDR_W-1:0]    SRAM_ADDR,
  output logic [DATA_W-1:0]    SRAM_Dout,
  input  logic [DATA_W-1:0]    SRAM_Din,
  output logic                 SRAM_OE_n,
  output logic                 SRAM_WE_n
);
  localparam int unsigned HEX_W = 4 * NUM_HEX;
  localparam logic [ADDR_W-1:0] SW_HEX_ADDR = ADDR_W'(sw_hex_addr(ADDR_W));
`ifdef MEM_IO_LED_EN
  localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(led_addr(ADDR_W));
`endif

  state_e            state_q, state_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [HEX_W-1:0]  hex_q, hex_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_dout_q, sram_dout_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
`ifdef MEM_IO_LED_EN
  logic [SW_W-1:0]   led_q, led_d;
`endif
  logic              ctr_load_c, ctr_dec_c, ctr_done_c;

  // Wait-state timer for SRAM strobes.
  mem_io_wait_ctr #(.WAIT_CYC(WAIT_CYC)) u_wait_ctr (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load_i   (ctr_load_c),
    .dec_i    (ctr_dec_c),
    .done_c_o (ctr_done_c)
  );

  // Next-state and next-output logic; strobes default inactive.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    hex_d       = hex_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    ready_d     = 1'b0;
    ctr_load_c  = 1'b0;
    ctr_dec_c   = 1'b0;
`ifdef MEM_IO_LED_EN
    led_d       = led_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu.Req) begin
          wr_d = cpu.Wr;
          if (cpu.Addr == SW_HEX_ADDR) begin
            if (cpu.Wr) hex_d = cpu.Wdata[HEX_W-1:0];
            else        rdata_d = DATA_W'(Switches);
            state_d = DONE;
            ready_d = 1'b1;
          end
`ifdef MEM_IO_LED_EN
          else if (cpu.Addr == LED_ADDR) begin
            if (cpu.Wr) led_d = cpu.Wdata[SW_W-1:0];
            else        rdata_d = DATA_W'(led_q);
            state_d = DONE;
            ready_d = 1'b1;
          end
`endif
          else begin
            state_d     = ACCESS;
            ctr_load_c  = 1'b1;
            sram_addr_d = cpu.Addr;
            sram_dout_d = cpu.Wr ? cpu.Wdata : '0;
            oe_n_d      = cpu.Wr;
            we_n_d      = ~cpu.Wr;
          end
        end
      end
      ACCESS: begin
        if (ctr_done_c) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (!wr_q) rdata_d = SRAM_Din;
        end else begin
          ctr_dec_c = 1'b1;
          oe_n_d    = oe_n_q;
          we_n_d    = we_n_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      hex_q       <= '0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
`ifdef MEM_IO_LED_EN
      led_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      hex_q       <= hex_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
`ifdef MEM_IO_LED_EN
      led_q       <= led_d;
`endif
    end
  end

  assign cpu.Rdata = rdata_q;
  assign cpu.Ready = ready_q;
  assign cpu.Busy  = busy_q;
  assign Hex       = hex_q;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_Dout = sram_dout_q;
  assign SRAM_OE_n = oe_n_q;
  assign SRAM_WE_n = we_n_q;
`ifdef MEM_IO_LED_EN
  assign LED       = led_q;
`else
  assign LED       = '0;
`endif
endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: transaction-level reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_mem_io_bridge;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned SW_W     = 10;
  localparam int unsigned NUM_HEX  = 4;
  localparam int unsigned WAIT_CYC = 1;
  localparam int          SRAM_LEN = int'(WAIT_CYC) + 2;
`ifdef MEM_IO_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SW_W-1:0]   sw = '0;
  logic [15:0]       hex;
  logic [SW_W-1:0]   led;
  logic [15:0]       sram_addr, sram_dout;
  logic [15:0]       sram_din = '0;
  logic              oe_n, we_n;
  bit                chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  mem_io_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) cpu_if ();

  mem_io_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SW_W(SW_W), .NUM_HEX(NUM_HEX), .WAIT_CYC(WAIT_CYC)
  ) dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .cpu       (cpu_if),
    .Switches  (sw),
    .Hex       (hex),
    .LED       (led),
    .SRAM_ADDR (sram_addr),
    .SRAM_Dout (sram_dout),
    .SRAM_Din  (sram_din),
    .SRAM_OE_n (oe_n),
    .SRAM_WE_n (we_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted access occupies len cycles (1 for MMIO,
  // WAIT_CYC+2 for SRAM); k is the 1-based cycle within it, 0 when idle.
  int          k = 0;
  int          len = 0;
  bit          m_sram = 1'b0;
  bit          m_wr = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] e_rdata = '0;
  logic [15:0] e_hex = '0;
  logic [SW_W-1:0] e_led = '0;

  function automatic bit goes_to_sram(input logic [15:0] a);
    return !(a == 16'hFFFF || (LED_EN && a == 16'hFFFE));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0; len <= 0; m_sram <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0;
      e_rdata <= '0; e_hex <= '0; e_led <= '0;
    end else if (k != 0) begin
      if (m_sram && !m_wr && k == SRAM_LEN - 1) e_rdata <= sram_din;
      k <= (k == len) ? 0 : k + 1;
    end else if (cpu_if.Req) begin
      m_wr    <= cpu_if.Wr;
      m_addr  <= cpu_if.Addr;
      m_wdata <= cpu_if.Wdata;
      m_sram  <= goes_to_sram(cpu_if.Addr);
      len     <= goes_to_sram(cpu_if.Addr) ? SRAM_LEN : 1;
      k       <= 1;
      if (cpu_if.Addr == 16'hFFFF) begin
        if (cpu_if.Wr) e_hex <= cpu_if.Wdata;
        else           e_rdata <= 16'(sw);
      end else if (LED_EN && cpu_if.Addr == 16'hFFFE) begin
        if (cpu_if.Wr) e_led <= cpu_if.Wdata[SW_W-1:0];
        else           e_rdata <= 16'(e_led);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("ready", 32'(cpu_if.Ready), 32'(k != 0 && k == len));
      check("busy", 32'(cpu_if.Busy), 32'(k != 0));
      check("rdata", 32'(cpu_if.Rdata), 32'(e_rdata));
      check("hex", 32'(hex), 32'(e_hex));
      check("led", 32'(led), 32'(e_led));
      check("oe_n", 32'(oe_n), 32'(!(m_sram && !m_wr && k >= 1 && k < SRAM_LEN)));
      check("we_n", 32'(we_n), 32'(!(m_sram && m_wr && k >= 1 && k < SRAM_LEN)));
      check("strobe_excl", 32'(oe_n | we_n), 32'd1);
      if (m_sram && k >= 1 && k < SRAM_LEN) begin
        check("sram_addr", 32'(sram_addr), 32'(m_addr));
        if (m_wr) check("sram_dout", 32'(sram_dout), 32'(m_wdata));
      end
    end
  end

  // One access from an idle bridge; reports Ready latency and strobe activity.
  task automatic do_access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat, output int oe_cnt, output int we_cnt,
                           output logic [15:0] st_addr);
    int guard;
    lat = 0; oe_cnt = 0; we_cnt = 0; st_addr = '0; guard = 0;
    @(negedge clk);
    while (cpu_if.Busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    cpu_if.Req = 1'b1; cpu_if.Wr = wr; cpu_if.Addr = addr; cpu_if.Wdata = wdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      cpu_if.Req = 1'b0;
      if (!oe_n) begin oe_cnt++; st_addr = sram_addr; end
      if (!we_n) begin we_cnt++; st_addr = sram_addr; end
      if (cpu_if.Ready) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, oe_cnt, we_cnt, rdy, cyc, cnt;
    logic [15:0] st_addr;
    cpu_if.Req = 1'b0; cpu_if.Wr = 1'b0; cpu_if.Addr = '0; cpu_if.Wdata = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cpu_if.Ready), 32'd0);
    check("rst_busy", 32'(cpu_if.Busy), 32'd0);
    check("rst_rdata", 32'(cpu_if.Rdata), 32'd0);
    check("rst_hex", 32'(hex), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_oe_we", 32'({oe_n, we_n}), 32'd3);
    check("rst_sram", 32'({sram_addr, sram_dout}), 32'd0);
    chk_en = 1'b1;

    // SRAM read, fixed data
    sram_din = 16'hBEEF;
    do_access(1'b0, 16'h0010, 16'h0000, lat, oe_cnt, we_cnt, st_addr);
    check("rd_lat", 32'(lat), 32'd3);
    check("rd_oe_cycles", 32'(oe_cnt), 32'd2);
    check("rd_we_cycles", 32'(we_cnt), 32'd0);
    check("rd_addr", 32'(st_addr), 32'h0010);
    check("rd_data", 32'(cpu_if.Rdata), 32'hBEEF);

    // Hex write
    do_access(1'b1, 16'hFFFF, 16'h1234, lat, oe_cnt, we_cnt, st_addr);
    check("hex_lat", 32'(lat), 32'd1);
    check("hex_val", 32'(hex), 32'h1234);
    check("hex_strobes", 32'(oe_cnt + we_cnt), 32'd0);
    check("hex_rdata_kept", 32'(cpu_if.Rdata), 32'hBEEF);

    // Switch read
    sw = 10'h2A5;
    do_access(1'b0, 16'hFFFF, 16'h0000, lat, oe_cnt, we_cnt, st_addr);
    check("sw_lat", 32'(lat), 32'd1);
    check("sw_rdata", 32'(cpu_if.Rdata), 32'h02A5);
    check("sw_strobes", 32'(oe_cnt + we_cnt), 32'd0);

    // LED register or SRAM fall-through at all-ones minus one
    do_access(1'b1, 16'hFFFE, 16'h03FF, lat, oe_cnt, we_cnt, st_addr);
    if (LED_EN) begin
      check("led_lat", 32'(lat), 32'd1);
      check("led_val", 32'(led), 32'h3FF);
      check("led_we", 32'(we_cnt), 32'd0);
    end else begin
      check("fffe_lat", 32'(lat), 32'd3);
      check("fffe_we", 32'(we_cnt), 32'd2);
      check("fffe_addr", 32'(st_addr), 32'hFFFE);
      check("fffe_led", 32'(led), 32'd0);
    end

    // Req held high: one access per idle acceptance
    @(negedge clk);
    cpu_if.Req = 1'b1; cpu_if.Wr = 1'b1; cpu_if.Addr = 16'h0123; cpu_if.Wdata = 16'h7777;
    rdy = 0; cyc = 0; cnt = 0;
    while (rdy < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!we_n) cnt++;
      if (cpu_if.Ready) rdy++;
    end
    cpu_if.Req = 1'b0;
    check("hold_cycles", 32'(cyc), 32'd15);
    check("hold_we_cycles", 32'(cnt), 32'd8);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_if.Busy || cpu_if.Ready) cnt++;
    end
    check("hold_no_queue", 32'(cnt), 32'd0);

    // Reset during an SRAM write strobe
    do_access(1'b1, 16'hFFFF, 16'hA5C3, lat, oe_cnt, we_cnt, st_addr);
    check("pre_rst_hex", 32'(hex), 32'hA5C3);
    @(negedge clk);
    cpu_if.Req = 1'b1; cpu_if.Wr = 1'b1; cpu_if.Addr = 16'h0040; cpu_if.Wdata = 16'h5555;
    @(negedge clk);
    cpu_if.Req = 1'b0;
    check("pre_rst_we_n", 32'(we_n), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_we_n", 32'(we_n), 32'd1);
    check("rst_mid_ready", 32'(cpu_if.Ready), 32'd0);
    check("rst_mid_busy", 32'(cpu_if.Busy), 32'd0);
    check("rst_mid_hex", 32'(hex), 32'd0);
    check("rst_mid_rdata", 32'(cpu_if.Rdata), 32'd0);
    check("rst_mid_sram", 32'({sram_addr, sram_dout}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_if.Ready) cnt++;
    end
    check("rst_no_ready", 32'(cnt), 32'd0);
    sram_din = 16'h3C5A;
    do_access(1'b0, 16'h0200, 16'h0000, lat, oe_cnt, we_cnt, st_addr);
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_rdata", 32'(cpu_if.Rdata), 32'h3C5A);

    // Randomized traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sw           = SW_W'($urandom);
      sram_din     = 16'($urandom);
      cpu_if.Req   = ($urandom_range(0, 3) != 0);
      cpu_if.Wr    = 1'($urandom_range(0, 1));
      cpu_if.Wdata = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       cpu_if.Addr = 16'hFFFF;
        1:       cpu_if.Addr = 16'hFFFE;
        default: cpu_if.Addr = 16'($urandom);
      endcase
    end
    @(negedge clk);
    cpu_if.Req = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
